// File: rtl/remote_comm_pkg.sv
// Shared types and constants for the remote_comm host-side command transmitter.
package remote_comm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } tx_state_e;

    localparam int BAUD_DIV_DEF = 2604;

    localparam logic [7:0]  POS_ACK  = 8'hA5;
    localparam logic [15:0] CAL_GYRO = 16'h2000;
    localparam logic [15:0] MOVE_N2  = 16'h4002;

    // Baud counters are at least 12 bits so any BAUD_DIV up to 4095 fits.
    function automatic int cnt_width(input int div);
        return ($clog2(div + 1) > 12) ? $clog2(div + 1) : 12;
    endfunction

endpackage

// File: rtl/remote_comm_if.sv
// Command/response bus between a host driver and remote_comm.
interface remote_comm_if;
    import remote_comm_pkg::*;

    // snd_cmd is a one-cycle strobe; it is accepted only when state_dbg is IDLE,
    // and cmd is sampled on that same cycle. cmd_snt and resp_rdy are levels.
    logic [15:0] cmd;
    logic        snd_cmd;
    logic        cmd_snt;
    logic [7:0]  resp;
    logic        resp_rdy;
    tx_state_e   state_dbg;

    modport master (
        output cmd, snd_cmd,
        input  cmd_snt, resp, resp_rdy, state_dbg
    );

    modport slave (
        input  cmd, snd_cmd,
        output cmd_snt, resp, resp_rdy, state_dbg
    );

endinterface

// File: rtl/remote_comm_uart.sv
// 8N1 UART: uart_tx serializer, uart_rx deserializer, and the uart pair wrapper.
module uart_tx import remote_comm_pkg::*; #(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);
    localparam int CW = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV - 1);

    logic [7:0]    shift_q, shift_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    // tx_done marks the last clock of the stop bit, so a trmt on that cycle
    // chains the next frame with no idle gap.
    always_comb begin
        shift_d = shift_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        tx_d    = tx_q;
        bit_end = busy_q && (baud_q == BIT_END);
        tx_done = bit_end && (idx_q == 4'd9);
        if (trmt) begin
            shift_d = tx_data;
            baud_d  = '0;
            idx_d   = 4'd0;
            busy_d  = 1'b1;
            tx_d    = 1'b0;
        end else if (bit_end) begin
            baud_d = '0;
            if (idx_q == 4'd9) begin
                busy_d = 1'b0;
                tx_d   = 1'b1;
            end else begin
                idx_d   = idx_q + 4'd1;
                shift_d = {1'b1, shift_q[7:1]};
                tx_d    = shift_q[0];
            end
        end else if (busy_q) begin
            baud_d = baud_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '1;
            baud_q  <= '0;
            idx_q   <= 4'd0;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            shift_q <= shift_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            tx_q    <= tx_d;
        end
    end

    assign TX = tx_q;

endmodule

module uart_rx import remote_comm_pkg::*; #(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic       rdy,
    output logic [7:0] rx_data
);
    localparam int CW = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

    logic          rx_ff1_q, rx_ff1_d, rx_ff2_q, rx_ff2_d, rx_prev_q, rx_prev_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          rdy_q, rdy_d;
    logic          sample;

    always_comb begin
        rx_ff1_d  = RX;
        rx_ff2_d  = rx_ff1_q;
        rx_prev_d = rx_ff2_q;
        busy_d    = busy_q;
        baud_d    = baud_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        rdy_d     = rdy_q;
        sample    = busy_q && (baud_q == ((idx_q == 4'd0) ? HALF_END : BIT_END));
        if (clr_rdy) rdy_d = 1'b0;
        if (!busy_q) begin
            if (rx_prev_q && !rx_ff2_q) begin
                busy_d = 1'b1;
                baud_d = '0;
                idx_d  = 4'd0;
            end
        end else if (sample) begin
            baud_d = '0;
            idx_d  = idx_q + 4'd1;
            if (idx_q == 4'd0) begin
                // Line back high mid-start is a glitch: drop it, keep the old byte.
                if (rx_ff2_q) busy_d = 1'b0;
                else          rdy_d  = 1'b0;
            end else if (idx_q <= 4'd8) begin
                shift_d = {rx_ff2_q, shift_q[7:1]};
            end else begin
                data_d = shift_q;
                rdy_d  = 1'b1;
                busy_d = 1'b0;
            end
        end else begin
            baud_d = baud_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ff1_q  <= 1'b1;
            rx_ff2_q  <= 1'b1;
            rx_prev_q <= 1'b1;
            busy_q    <= 1'b0;
            baud_q    <= '0;
            idx_q     <= 4'd0;
            shift_q   <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
        end else begin
            rx_ff1_q  <= rx_ff1_d;
            rx_ff2_q  <= rx_ff2_d;
            rx_prev_q <= rx_prev_d;
            busy_q    <= busy_d;
            baud_q    <= baud_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
        end
    end

    assign rdy     = rdy_q;
    assign rx_data = data_q;

endmodule

module uart import remote_comm_pkg::*; #(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       TX,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic       rdy,
    output logic [7:0] rx_data
);
    uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data), .TX(TX), .tx_done(tx_done)
    );

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rdy(clr_rdy), .rdy(rdy), .rx_data(rx_data)
    );

endmodule

// File: rtl/remote_comm.sv
// Host-side remote: sends a 16-bit command as two UART bytes (high first)
// and presents response bytes received from the robot.
module remote_comm import remote_comm_pkg::*; #(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    remote_comm_if.slave   bus,
    output logic           TX,
    input  logic           RX
);
    tx_state_e   state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic        start_q, start_d;
    logic        cmd_snt_q, cmd_snt_d;
    logic        accept, trmt, tx_done;
    logic [7:0]  tx_data;

    // start_q delays the high-byte kick by one clock so the start bit begins
    // on the edge after the strobe is sampled.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        start_d   = 1'b0;
        cmd_snt_d = cmd_snt_q;
        accept    = 1'b0;
        trmt      = start_q;
        tx_data   = start_q ? cmd_q[15:8] : cmd_q[7:0];
        case (state_q)
            IDLE: begin
                if (bus.snd_cmd) begin
                    accept    = 1'b1;
                    cmd_d     = bus.cmd;
                    cmd_snt_d = 1'b0;
                    start_d   = 1'b1;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (tx_done) begin
                    trmt    = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (tx_done) begin
                    cmd_snt_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            start_q   <= 1'b0;
            cmd_snt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            start_q   <= start_d;
            cmd_snt_q <= cmd_snt_d;
        end
    end

    uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .tx_done (tx_done),
        .TX      (TX),
        .RX      (RX),
        .clr_rdy (accept),
        .rdy     (bus.resp_rdy),
        .rx_data (bus.resp)
    );

    assign bus.cmd_snt   = cmd_snt_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_remote_comm.sv
// Randomized self-checking bench for remote_comm with a frame-level reference model.
module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int B = 16;

    logic clk;
    logic rst_n;
    logic tx;
    logic rx_drv;
    logic loopback;
    logic rx_line;

    int n_checks;
    int n_errors;

    logic [7:0] exp_q[$];
    logic [7:0] tx_got[$];
    logic [7:0] rx_got[$];
    time        rx_time[$];
    logic [7:0] m_resp;
    time        t_acc;
    time        t_fall;

    remote_comm_if bus();

    assign rx_line = loopback ? tx : rx_drv;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .TX    (tx),
        .RX    (rx_line)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // TX line decoder: samples the middle of every bit, independent of DUT internals.
    initial begin
        int cnt;
        int idx;
        logic [7:0] sh;
        bit busy;
        busy = 0; cnt = 0; idx = 0; sh = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0;
            end else if (!busy) begin
                if (tx === 1'b0) begin
                    busy = 1; cnt = 0; idx = 0;
                end
            end else begin
                cnt++;
                if (cnt == B / 2 + idx * B) begin
                    if (idx == 0) begin
                        check("tx_start_bit", tx, 1'b0);
                    end else if (idx <= 8) begin
                        sh = {tx, sh[7:1]};
                    end else begin
                        check("tx_stop_bit", tx, 1'b1);
                        tx_got.push_back(sh);
                        busy = 0;
                    end
                    idx++;
                end
            end
        end
    end

    // Response monitor: records resp on each rising resp_rdy.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.resp_rdy === 1'b1 && prev !== 1'b1) begin
                rx_got.push_back(bus.resp);
                rx_time.push_back($time);
            end
            prev = bus.resp_rdy;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [15:0] w);
        @(negedge clk);
        bus.cmd = w;
        bus.snd_cmd = 1'b1;
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        bus.snd_cmd = 1'b0;
        check("acc_state", bus.state_dbg, HIGH);
        check("acc_snt_clr", bus.cmd_snt, 1'b0);
        check("acc_rdy_clr", bus.resp_rdy, 1'b0);
        check("acc_tx_still_idle", tx, 1'b1);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        @(negedge clk);
        check("tx_start_edge", tx, 1'b0);
    endtask

    task automatic wait_cmd_snt();
        bit seen;
        longint delta;
        seen = 0;
        for (int k = 0; k < 25 * B; k++) begin
            @(negedge clk);
            if (bus.cmd_snt === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("snt_seen", seen, 1'b1);
        if (seen) begin
            delta = longint'(($time - 5 - t_acc) / 10);
            check("snt_timing", (delta >= 20 * B && delta <= 20 * B + 2), 1'b1);
        end
    endtask

    task automatic compare_tx();
        check("tx_byte_count", tx_got.size(), exp_q.size());
        while (tx_got.size() > 0 && exp_q.size() > 0)
            check("tx_byte", tx_got.pop_front(), exp_q.pop_front());
        tx_got.delete();
        exp_q.delete();
    endtask

    task automatic rx_drive(input logic [7:0] b);
        @(negedge clk);
        rx_drv = 1'b0;
        t_fall = $time;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (B) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    task automatic rx_check(input logic [7:0] b);
        longint lat;
        rx_got.delete();
        rx_time.delete();
        fork
            rx_drive(b);
            begin
                repeat (B + 2) @(negedge clk);
                check("rdy_clr_on_start", bus.resp_rdy, 1'b0);
                check("resp_hold", bus.resp, m_resp);
            end
        join
        check("rx_count", rx_got.size(), 1);
        if (rx_got.size() > 0) begin
            check("rx_data", rx_got[0], b);
            lat = longint'((rx_time[0] - t_fall) / 10);
            check("rx_latency", (lat >= 9 * B && lat <= (19 * B) / 2 + 4), 1'b1);
        end
        m_resp = b;
    endtask

    // ---------------- sequence ----------------
    initial begin
        logic [15:0] w;
        logic [7:0]  b;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; bus.cmd = '0; bus.snd_cmd = 1'b0;
        rx_drv = 1'b1; loopback = 1'b0; m_resp = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_snt", bus.cmd_snt, 1'b0);
        check("rst_rdy", bus.resp_rdy, 1'b0);
        check("rst_resp", bus.resp, 8'h00);
        check("rst_state", bus.state_dbg, IDLE);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic command.
        send_cmd(MOVE_N2);
        wait_cmd_snt();
        compare_tx();
        repeat (10) @(negedge clk);
        check("snt_hold", bus.cmd_snt, 1'b1);

        // Response bytes, resp_rdy clears on the next start bit.
        rx_check(POS_ACK);
        check("rdy_level", bus.resp_rdy, 1'b1);
        rx_check(8'h3C);

        // False start leaves resp/resp_rdy untouched.
        rx_got.delete();
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * B) @(negedge clk);
        check("fs_rdy", bus.resp_rdy, 1'b1);
        check("fs_resp", bus.resp, m_resp);
        check("fs_no_byte", rx_got.size(), 0);

        // Back-to-back commands.
        send_cmd(16'h5BF1);
        wait_cmd_snt();
        send_cmd(16'h47F1);
        wait_cmd_snt();
        compare_tx();

        // Strobe mid-transmission and on the completion cycle are both ignored.
        send_cmd(16'h9C6E);
        repeat (5 * B) @(negedge clk);
        bus.cmd = 16'hFFFF;
        bus.snd_cmd = 1'b1;
        @(negedge clk);
        bus.snd_cmd = 1'b0;
        check("mid_ignore_state", bus.state_dbg, HIGH);
        while ($time < t_acc + (20 * B + 1) * 10 - 5) @(negedge clk);
        check("snt_not_early", bus.cmd_snt, 1'b0);
        bus.cmd = 16'h1111;
        bus.snd_cmd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.snd_cmd = 1'b0;
        check("boundary_snt", bus.cmd_snt, 1'b1);
        check("boundary_idle", bus.state_dbg, IDLE);
        repeat (3 * B) @(negedge clk);
        check("boundary_tx_idle", tx, 1'b1);
        compare_tx();

        // Reset in the middle of the high byte.
        send_cmd(16'hC3A7);
        repeat (4 * B) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_snt", bus.cmd_snt, 1'b0);
        check("midrst_state", bus.state_dbg, IDLE);
        check("midrst_rdy", bus.resp_rdy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        tx_got.delete();
        m_resp = 8'h00;
        check("midrst_resp", bus.resp, 8'h00);
        repeat (5) @(negedge clk);
        check("post_rst_no_tx", tx_got.size(), 0);
        send_cmd(16'h53F2);
        wait_cmd_snt();
        compare_tx();

        // Full duplex: command out while a response comes in.
        fork
            begin
                send_cmd(16'hE718);
                wait_cmd_snt();
            end
            begin
                repeat (2) @(negedge clk);
                rx_check(8'h96);
            end
        join
        compare_tx();

        // Loopback: two responses equal to the two command bytes.
        loopback = 1'b1;
        rx_got.delete();
        rx_time.delete();
        send_cmd(16'h1234);
        wait_cmd_snt();
        repeat (B) @(negedge clk);
        check("lb_count", rx_got.size(), 2);
        if (rx_got.size() >= 2) begin
            check("lb_first", rx_got[0], 8'h12);
            check("lb_second", rx_got[1], 8'h34);
        end
        compare_tx();
        loopback = 1'b0;
        m_resp = 8'h34;
        repeat (4) @(negedge clk);

        // Random traffic.
        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            repeat ($urandom_range(1, 20)) @(negedge clk);
            send_cmd(w);
            wait_cmd_snt();
            compare_tx();
        end
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 20)) @(negedge clk);
            rx_check(b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
